// File: rtl/mpy_const_seq.sv
// rtl/mpy_const_seq.sv - sequential shift-add multiply of a signed operand by a constant
// Ports:
//   clk   - clock, all state updates on the rising edge
//   rst   - synchronous active-high reset
//   start - request a multiply of a, accepted only in IDLE
//   a     - signed multiplicand, captured on the accepted start edge
//   busy  - high while the operation is in RUN or DONE
//   done  - one-cycle pulse marking y valid
//   y     - signed product a*K, held until the next operation completes
module mpy_const_seq #(
   parameter int          W  = 8,
   parameter int          KW = 4,
   parameter int unsigned K  = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic signed [W-1:0]    a,
   output logic                   busy,
   output logic                   done,
   output logic signed [W+KW-1:0] y
);

   localparam int            PW     = W + KW;
   localparam int            CW     = (KW > 1) ? $clog2(KW) : 1;
   localparam logic [KW-1:0] K_BITS = KW'(K);
   localparam logic [CW-1:0] I_LAST = CW'(KW - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state;
   state_t               state_next;
   logic signed [W-1:0]  a_reg;
   logic signed [PW-1:0] acc;
   logic [CW-1:0]        i;

   logic signed [PW-1:0] a_ext;
   logic signed [PW-1:0] addend;
   logic signed [PW-1:0] acc_sum;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; every constant bit costs one RUN cycle, zero or not,
   // so the latency never depends on a or K.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (i == I_LAST) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   // Partial product for bit i: the operand is sign-extended to the full
   // product width first so shifted negative values stay exact.
   always_comb begin
      a_ext   = {{KW{a_reg[W-1]}}, a_reg};
      addend  = K_BITS[i] ? (a_ext <<< i) : '0;
      acc_sum = acc + addend;
   end

   // Datapath; y is written only on the edge that leaves RUN, so it stays
   // stable between completions.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg <= '0;
         acc   <= '0;
         i     <= '0;
         y     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_reg <= a;
                  acc   <= '0;
                  i     <= '0;
               end
            end
            RUN: begin
               acc <= acc_sum;
               i   <= i + CW'(1);
               if (i == I_LAST) begin
                  y <= acc_sum;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mpy_const_seq.sv
// tb/tb_mpy_const_seq.sv - scoreboard testbench for mpy_const_seq
module tb_mpy_const_seq;

   localparam int W  = 8;
   localparam int KW = 4;
   localparam int PW = W + KW;
   localparam int NI = 4;
   localparam int KS [NI] = '{10, 0, 1, 15};

   typedef struct packed {
      logic [NI-1:0][PW-1:0] y;
      int                    due;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  start;
   logic signed [W-1:0]   a;
   logic [NI-1:0]         busy_v;
   logic [NI-1:0]         done_v;
   logic [NI-1:0][PW-1:0] y_v;

   int checks = 0;
   int errors = 0;

   // Reference model state, owned by the model/monitor process
   int                    cyc = 0;
   int                    cnt = 0;
   exp_t                  sb[$];
   logic [NI-1:0][PW-1:0] last_y = '0;

   always #5 clk = ~clk;

   for (genvar j = 0; j < NI; j++) begin : g_dut
      mpy_const_seq #(
         .W  (W),
         .KW (KW),
         .K  (KS[j])
      ) dut (
         .clk   (clk),
         .rst   (rst),
         .start (start),
         .a     (a),
         .busy  (busy_v[j]),
         .done  (done_v[j]),
         .y     (y_v[j])
      );
   end

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Model at the rising edge, monitor on the falling edge
   always begin
      @(posedge clk);
      cyc++;
      if (rst) begin
         cnt = 0;
         sb.delete();
         last_y = '0;
      end else if (cnt == 0) begin
         if (start) begin
            exp_t e;
            int   av;
            av = int'(a);
            for (int j = 0; j < NI; j++) e.y[j] = PW'(av * KS[j]);
            e.due = cyc + KW;
            sb.push_back(e);
            cnt = KW + 1;
         end
      end else begin
         cnt--;
      end

      @(negedge clk);
      for (int j = 0; j < NI; j++) begin
         check($sformatf("busy_k%0d", KS[j]), int'(busy_v[j]), int'(cnt != 0));
         check($sformatf("done_k%0d", KS[j]), int'(done_v[j]), int'(cnt == 1));
      end
      if (done_v[0]) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("latency", cyc, e.due);
            last_y = e.y;
         end
      end
      for (int j = 0; j < NI; j++) begin
         check($sformatf("y_k%0d", KS[j]), int'($signed(y_v[j])), int'($signed(last_y[j])));
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (cnt != 0 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (cnt != 0) check("idle_timeout", 0, 1);
   endtask

   // One start pulse; a is scrambled right after acceptance
   task automatic op(input int v);
      wait_idle();
      a     = W'(v);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = W'($urandom);
   endtask

   task automatic count_window(input int n, output int nb, output int nd);
      nb = 0;
      nd = 0;
      for (int t = 0; t < n; t++) begin
         @(negedge clk);
         nb += int'(busy_v[0]);
         nd += int'(done_v[0]);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int nb, nd;
      int dc[$];

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", int'(busy_v[0]), 0);
      check("rst_done", int'(done_v[0]), 0);
      check("rst_y", int'($signed(y_v[0])), 0);
      @(posedge clk);
      #1;

      // a = -7: five busy cycles, one done, y = -70
      op(-7);
      count_window(9, nb, nd);
      check("m7_busy_cycles", nb, 5);
      check("m7_done_count", nd, 1);
      check("m7_y", int'($signed(y_v[0])), -70);

      op(127);
      wait_idle();
      check("p127_y", int'($signed(y_v[0])), 1270);
      op(-128);
      wait_idle();
      check("m128_y", int'($signed(y_v[0])), -1280);
      op(0);
      wait_idle();
      check("zero_y", int'($signed(y_v[0])), 0);

      // start re-pulsed in RUN and in DONE, a toggled during RUN
      wait_idle();
      a     = 8'sd21;
      start = 1'b1;
      @(posedge clk); #1;                 // E0 accepted
      start = 1'b0;
      @(posedge clk); #1;                 // after E1 (RUN)
      start = 1'b1;
      a     = 8'sd55;
      @(posedge clk); #1;                 // after E2
      start = 1'b0;
      a     = -8'sd3;
      @(posedge clk); #1;                 // after E3
      @(posedge clk); #1;                 // after E4, now in DONE
      start = 1'b1;
      @(posedge clk); #1;                 // E5 sampled start in DONE
      start = 1'b0;
      count_window(8, nb, nd);
      check("ignore_done_count", nd, 0);
      check("ignore_y", int'($signed(y_v[0])), 210);

      // reset in the 2nd RUN cycle aborts the operation
      op(20);                             // returns after E0
      @(posedge clk); #1;                 // after E1: second RUN cycle
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy", int'(busy_v[0]), 0);
      check("abort_done", int'(done_v[0]), 0);
      check("abort_y", int'($signed(y_v[0])), 0);
      count_window(10, nb, nd);
      check("abort_no_done", nd, 0);

      // first start after reset, then start held high for three operations
      wait_idle();
      a     = 8'sd3;
      start = 1'b1;
      for (int t = 0; t < 20; t++) begin
         @(posedge clk);
         #1;
         if (t == 0) a = -8'sd1;
         if (t == 6) a = 8'sd50;
         if (t == 12) begin
            start = 1'b0;
            a     = '0;
         end
         if (done_v[0]) dc.push_back(t);
      end
      check("b2b_done_count", dc.size(), 3);
      if (dc.size() == 3) begin
         check("b2b_first", dc[0], KW);
         check("b2b_gap1", dc[1] - dc[0], KW + 2);
         check("b2b_gap2", dc[2] - dc[1], KW + 2);
      end
      check("b2b_last_y", int'($signed(y_v[0])), 500);

      // exhaustive sweep, all four constants in parallel
      for (int v = -128; v <= 127; v++) op(v);
      wait_idle();
      repeat (2) @(posedge clk);
      #1;
      check("sb_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/mpy_const_seq.md
MPY_CONST_SEQ -- requirements
Module: mpy_const_seq

Interface
REQ-001 The module SHALL have parameter W, default 8, giving the signed multiplicand width.
REQ-002 The module SHALL have parameter KW, default 4, giving the unsigned constant width.
REQ-003 The module SHALL have parameter K, default 10, giving the unsigned constant multiplier, with 0 <= K < 2**KW.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port start, input, 1 bit: request a multiply of a; honoured only in IDLE.
REQ-007 The module SHALL have port a, input, signed [W-1:0]: the multiplicand, sampled only on the accepted start edge.
REQ-008 The module SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-009 The module SHALL have port done, output, 1 bit: one-cycle pulse marking y valid.
REQ-010 The module SHALL have port y, output, signed [W+KW-1:0]: the product a*K.

Function
REQ-011 The block SHALL compute y = a*K iteratively, one constant bit per RUN cycle: acc += sext(a_reg) << i when K[i]=1, for i = 0..KW-1, LSB first.
REQ-012 The block SHALL sign-extend a_reg to W+KW bits before shifting, so negative a gives the exact two's-complement product.
REQ-013 All arithmetic SHALL be W+KW bits wide; the result never overflows because |a*K| <= 2**(W-1)*(2**KW-1).
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 In IDLE with start=1 at an edge, the block SHALL capture a into a_reg, clear acc and bit counter i, and enter RUN.
REQ-016 In IDLE with start=0, the block SHALL hold all state, and y SHALL keep its last value.
REQ-017 Each RUN edge SHALL perform one conditional add and increment i; the edge processing i=KW-1 SHALL load y with the final sum and enter DONE.
REQ-018 In DONE, done SHALL be 1 for exactly one cycle, and the next edge SHALL return to IDLE unconditionally.
REQ-019 Latency SHALL be fixed: start accepted at edge E0 gives done=1 in the cycle after edge E0+KW (4 cycles for the defaults), regardless of a or K.
REQ-020 There SHALL be no zero-bit skipping; K=0 SHALL yield y=0 after the full latency.
REQ-021 start while busy=1 (RUN or DONE) SHALL be ignored, not queued.
REQ-022 start held high continuously SHALL produce back-to-back operations every KW+2 cycles, with a resampled on each IDLE acceptance.
REQ-023 Changes on a after acceptance SHALL NOT affect the result in flight.
REQ-024 y SHALL change only on the edge entering DONE, and SHALL remain stable until the next operation completes.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE and clear i, acc, a_reg and y to 0, with busy=0 and done=0.
REQ-026 rst SHALL take priority over start and over any in-progress operation; a reset mid-RUN or in DONE SHALL abort without asserting done.
REQ-027 The first start after rst deasserts SHALL be accepted normally.

Verification (defaults W=8, KW=4, K=10)
REQ-028 Directed case: after reset, start with a=-7 -> busy=1 for 5 cycles, done pulses once 4 cycles after the start edge, y=12'hFBA (-70).
REQ-029 Directed case: a=127 gives y=12'h4F6 (1270); a=-128 gives y=12'hB00 (-1280); a=0 gives y=0. Each SHALL be checked exactly against the a*K model.
REQ-030 Directed case: start pulsed again in RUN and in DONE -> ignored, exactly one done; a toggled during RUN -> result still equals the captured a*10.
REQ-031 Directed case: rst asserted in the 2nd RUN cycle -> next cycle busy=0, done=0, y=0, and no done pulse follows.
REQ-032 Directed case: start held high for 3 operations with a = 3, -1, 50 -> done every 6 cycles, y = 30, -30 (12'hFE2), 500 (12'h1F4).
REQ-033 Sweep: exhaustive a in [-128, 127] for K in {0, 1, 10, 15} -> every y equals a*K, with fixed latency.
